// File: rtl/rtermcal_ctrl.sv
// ============================================================================
// rtermcal_ctrl : EG1D80V termination-calibration controller (SGIO linear
// search + LVDS 4-bit SAR). Option RTERMCAL_CTRL_MAJ_EN: 2-of-3 majority EVAL.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rtermcal_ctrl #(
  parameter int SETTLE_CYC  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        start_i,
  output logic [14:0] D_IOSG_O,
  output logic [3:0]  D_LVDS_O,
  output logic [1:0]  MODE_O,
  input  logic [1:0]  RESULT_I,
  output logic        busy_o,
  output logic        done_o,
  output logic [3:0]  sgio_code_o,
  output logic [3:0]  lvds_code_o,
  output logic        sgio_err_o,
  output logic        lvds_err_o
);

  localparam logic [7:0] C_SETTLE   = 8'(SETTLE_CYC);
  localparam logic [1:0] C_MODE_OFF = 2'b00;
  localparam logic [1:0] C_MODE_SG  = 2'b01;
  localparam logic [1:0] C_MODE_LV  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_SG_WAIT, S_SG_EVAL, S_LV_WAIT,
    S_LV_EVAL, S_LV_VWAIT, S_LV_VER, S_DONE
  } state_t;

  function automatic logic [14:0] f_therm(input logic [3:0] n);
    f_therm = '0;
    for (int k = 0; k < 15; k++)
      if (k < int'(n)) f_therm[k] = 1'b1;
  endfunction

  state_t      r_state, w_state;
  logic [7:0]  r_cnt, w_cnt;
  logic [3:0]  r_n, w_n;
  logic [1:0]  r_bit, w_bit;
  logic [3:0]  r_lv, w_lv;
  logic [14:0] r_iosg, w_iosg;
  logic [1:0]  r_mode, w_mode;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic [3:0]  r_sg_code, w_sg_code;
  logic [3:0]  r_sgio_code, w_sgio_code;
  logic [3:0]  r_lvds_code, w_lvds_code;
  logic        r_sg_err, w_sg_err;
  logic        r_lv_err, w_lv_err;

  logic [1:0]  r_sync [SYNC_STAGES];
  logic        w_raw, w_r, w_eval_last, w_in_eval;
  logic [3:0]  w_sg_fin, w_lv_dec;
  logic        w_sg_term;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= RESULT_I;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_raw     = (r_state == S_SG_EVAL) ? r_sync[SYNC_STAGES-1][0]
                                            : r_sync[SYNC_STAGES-1][1];
  assign w_in_eval = (r_state == S_SG_EVAL) || (r_state == S_LV_EVAL) ||
                     (r_state == S_LV_VER);

`ifdef RTERMCAL_CTRL_MAJ_EN
  // Two earlier samples are held; the decision is made on the third cycle.
  logic [1:0] r_ecnt;
  logic [1:0] r_samp;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_ecnt <= '0;
      r_samp <= '0;
    end else if (w_in_eval && !w_eval_last) begin
      r_samp[r_ecnt[0]] <= w_raw;
      r_ecnt            <= r_ecnt + 2'd1;
    end else begin
      r_ecnt <= '0;
    end
  end

  assign w_eval_last = (r_ecnt == 2'd2);
  assign w_r = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_raw) | (r_samp[1] & w_raw);
`else
  assign w_eval_last = 1'b1;
  assign w_r         = w_raw;
`endif

  assign w_sg_term = w_r || (r_n == 4'd15);
  assign w_sg_fin  = !w_r ? 4'd15 : ((r_n == 4'd0) ? 4'd0 : r_n - 4'd1);
  assign w_lv_dec  = w_r ? (r_lv & ~(4'b0001 << r_bit)) : r_lv;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_n         <= '0;
      r_bit       <= '0;
      r_lv        <= '0;
      r_iosg      <= '0;
      r_mode      <= C_MODE_OFF;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sg_code   <= '0;
      r_sgio_code <= '0;
      r_lvds_code <= '0;
      r_sg_err    <= 1'b0;
      r_lv_err    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_n         <= w_n;
      r_bit       <= w_bit;
      r_lv        <= w_lv;
      r_iosg      <= w_iosg;
      r_mode      <= w_mode;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_sg_code   <= w_sg_code;
      r_sgio_code <= w_sgio_code;
      r_lvds_code <= w_lvds_code;
      r_sg_err    <= w_sg_err;
      r_lv_err    <= w_lv_err;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_n         = r_n;
    w_bit       = r_bit;
    w_lv        = r_lv;
    w_iosg      = r_iosg;
    w_mode      = r_mode;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_sg_code   = r_sg_code;
    w_sgio_code = r_sgio_code;
    w_lvds_code = r_lvds_code;
    w_sg_err    = r_sg_err;
    w_lv_err    = r_lv_err;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_busy   = 1'b1;
          w_mode   = C_MODE_SG;
          w_n      = '0;
          w_iosg   = '0;
          w_lv     = '0;
          w_sg_err = 1'b0;
          w_lv_err = 1'b0;
          w_cnt    = C_SETTLE;
          w_state  = S_SG_WAIT;
        end
      end
      S_SG_WAIT, S_LV_WAIT, S_LV_VWAIT: begin
        // Leave the wait state on the cycle the counter hits zero.
        if (r_cnt <= 8'd1) begin
          w_cnt = '0;
          case (r_state)
            S_SG_WAIT: w_state = S_SG_EVAL;
            S_LV_WAIT: w_state = S_LV_EVAL;
            default:   w_state = S_LV_VER;
          endcase
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      S_SG_EVAL: begin
        if (w_eval_last) begin
          w_cnt = C_SETTLE;
          if (w_sg_term) begin
            w_sg_code = w_sg_fin;
            w_sg_err  = !w_r || (r_n == 4'd0);
            w_iosg    = f_therm(w_sg_fin);
            w_mode    = C_MODE_LV;
            w_lv      = 4'b1000;
            w_bit     = 2'd3;
            w_state   = S_LV_WAIT;
          end else begin
            w_n     = r_n + 4'd1;
            w_iosg  = f_therm(r_n + 4'd1);
            w_state = S_SG_WAIT;
          end
        end
      end
      S_LV_EVAL: begin
        if (w_eval_last) begin
          w_cnt = C_SETTLE;
          if (r_bit != 2'd0) begin
            w_lv    = w_lv_dec | (4'b0001 << (r_bit - 2'd1));
            w_bit   = r_bit - 2'd1;
            w_state = S_LV_WAIT;
          end else begin
            w_lv    = w_lv_dec;
            w_state = S_LV_VWAIT;
          end
        end
      end
      S_LV_VER: begin
        if (w_eval_last) begin
          w_lv_err    = w_r || (r_lv == 4'd15);
          w_lvds_code = r_lv;
          w_sgio_code = r_sg_code;
          w_done      = 1'b1;
          w_busy      = 1'b0;
          w_mode      = C_MODE_OFF;
          w_state     = S_DONE;
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  assign D_IOSG_O    = r_iosg;
  assign D_LVDS_O    = r_lv;
  assign MODE_O      = r_mode;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign sgio_code_o = r_sgio_code;
  assign lvds_code_o = r_lvds_code;
  assign sgio_err_o  = r_sg_err;
  assign lvds_err_o  = r_lv_err;

endmodule

`default_nettype wire

// File: tb/tb_rtermcal_ctrl.sv
// Testbench for rtermcal_ctrl: threshold cell model, directed and random runs.
`timescale 1ns/1ps
`default_nettype none

module tb_rtermcal_ctrl;

  localparam int S = 4;
`ifdef RTERMCAL_CTRL_MAJ_EN
  localparam int E = 3;
`else
  localparam int E = 1;
`endif

  logic        clk;
  logic        RST_I;
  logic        start_i;
  logic [14:0] D_IOSG_O;
  logic [3:0]  D_LVDS_O;
  logic [1:0]  MODE_O;
  logic [1:0]  RESULT_I;
  logic        busy_o, done_o;
  logic [3:0]  sgio_code_o, lvds_code_o;
  logic        sgio_err_o, lvds_err_o;

  int thr_sg, thr_lv;
  int vectors, miscompares;

  rtermcal_ctrl #(.SETTLE_CYC(S), .SYNC_STAGES(2)) dut (
    .CLK_I(clk), .RST_I(RST_I), .start_i(start_i),
    .D_IOSG_O(D_IOSG_O), .D_LVDS_O(D_LVDS_O), .MODE_O(MODE_O),
    .RESULT_I(RESULT_I), .busy_o(busy_o), .done_o(done_o),
    .sgio_code_o(sgio_code_o), .lvds_code_o(lvds_code_o),
    .sgio_err_o(sgio_err_o), .lvds_err_o(lvds_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell: result is 1 once the trimmed resistance falls below the reference.
  assign RESULT_I = {1'(int'(D_LVDS_O) >= thr_lv), 1'($countones(D_IOSG_O) >= thr_sg)};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Largest code whose compare result is 0; 0 when every code compares 1.
  function automatic int ref_code(input int thr);
    int c = 0;
    for (int k = 0; k < 16; k++) if (k < thr) c = k;
    return c;
  endfunction

  function automatic int ref_err(input int thr);
    return ((thr <= 0) || (ref_code(thr) == 15)) ? 1 : 0;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " D_IOSG"}, 32'(D_IOSG_O), 0);
    check({tag, " D_LVDS"}, 32'(D_LVDS_O), 0);
    check({tag, " MODE"}, 32'(MODE_O), 0);
    check({tag, " busy"}, 32'(busy_o), 0);
    check({tag, " done"}, 32'(done_o), 0);
    check({tag, " sgio_code"}, 32'(sgio_code_o), 0);
    check({tag, " lvds_code"}, 32'(lvds_code_o), 0);
    check({tag, " sgio_err"}, 32'(sgio_err_o), 0);
    check({tag, " lvds_err"}, 32'(lvds_err_o), 0);
  endtask

  task automatic run_and_check(input string tag, input int tsg, input int tlv, input bit spam);
    int c01 = 0, c10 = 0, c11 = 0, dones = 0;
    bit seen = 0;
    int esg, elv, trials;
    thr_sg = tsg;
    thr_lv = tlv;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check({tag, " busy after start"}, 32'(busy_o), 1);
    for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
      if (MODE_O == 2'b01) c01++;
      else if (MODE_O == 2'b10) c10++;
      else if (MODE_O == 2'b11) c11++;
      if (done_o) begin
        dones++;
        seen = 1;
        check({tag, " MODE in DONE"}, 32'(MODE_O), 0);
        check({tag, " busy in DONE"}, 32'(busy_o), 0);
      end
      if (spam) start_i = (busy_o || done_o) ? 1'($urandom_range(0, 1)) | done_o : 1'b0;
      @(negedge clk);
    end
    start_i = 1'b0;
    check({tag, " done seen"}, 32'(seen), 1);
    for (int k = 0; k < 4; k++) begin
      if (done_o) dones++;
      if (busy_o) dones += 100;
      @(negedge clk);
    end
    esg    = ref_code(tsg);
    elv    = ref_code(tlv);
    trials = ((tsg > 15) ? 15 : ((tsg < 0) ? 0 : tsg)) + 1;
    check({tag, " done pulses"}, 32'(dones), 1);
    check({tag, " MODE 11 cycles"}, 32'(c11), 0);
    check({tag, " MODE 01 cycles"}, 32'(c01), 32'(trials * (S + E)));
    check({tag, " MODE 10 cycles"}, 32'(c10), 32'(5 * (S + E)));
    check({tag, " sgio_code"}, 32'(sgio_code_o), 32'(esg));
    check({tag, " sgio_err"}, 32'(sgio_err_o), 32'(ref_err(tsg)));
    check({tag, " lvds_code"}, 32'(lvds_code_o), 32'(elv));
    check({tag, " lvds_err"}, 32'(lvds_err_o), 32'(ref_err(tlv)));
    check({tag, " D_IOSG"}, 32'(D_IOSG_O), (32'd1 << esg) - 32'd1);
    check({tag, " D_LVDS"}, 32'(D_LVDS_O), 32'(elv));
    check({tag, " MODE idle"}, 32'(MODE_O), 0);
  endtask

  initial begin
    bit reached;
    vectors     = 0;
    miscompares = 0;
    thr_sg      = 11;
    thr_lv      = 7;
    RST_I       = 1'b1;
    start_i     = 1'b0;
    repeat (3) @(negedge clk);
    RST_I = 1'b0;
    check_idle_outputs("reset");

    run_and_check("model", 11, 7, 0);
    check("model D_IOSG literal", 32'(D_IOSG_O), 32'h03FF);
    run_and_check("sg_tied1", 0, 7, 0);
    run_and_check("sg_tied0", 99, 7, 0);
    run_and_check("lv_tied1", 11, 0, 0);
    run_and_check("lv_tied0", 11, 99, 0);
    run_and_check("edge15", 15, 15, 0);
    run_and_check("edge1", 1, 1, 0);
    for (int i = 0; i < 8; i++)
      run_and_check($sformatf("rand%0d", i), int'($urandom_range(0, 17)),
                    int'($urandom_range(0, 17)), 0);
    run_and_check("spam", 11, 7, 1);

    // Abort mid-run in the LVDS phase.
    thr_sg = 11;
    thr_lv = 7;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    reached = 0;
    for (int cyc = 0; cyc < 2000 && !reached; cyc++) begin
      if (MODE_O == 2'b10) reached = 1;
      else @(negedge clk);
    end
    check("abort reached LVDS", 32'(reached), 1);
    repeat (20) @(negedge clk);
    check("abort still busy", 32'(busy_o), 1);
    RST_I = 1'b1;
    @(negedge clk);
    RST_I = 1'b0;
    check_idle_outputs("abort");
    repeat (10) @(negedge clk);
    check_idle_outputs("abort idle");
    run_and_check("after_abort", 11, 7, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
